cart_bank_ctrl: RTL and testbench

Cartridge bank-switching and load controller for the 2600 ROM datapath. It sits between the 6502 address bus, the SPI RAM slave, and the dual-port cartridge ROM. It maps CPU accesses in `0x1000-0x1FFF` onto a banked ROM of up to 32 KB using the F8, F6 and F4 hotspot schemes. It also sequences ESP32 cartridge loads: it holds and resets the CPU, steers SPI writes into ROM port B, and re-initialises the bank state before the CPU restarts.

---
 rtl/cart_bank_ctrl.sv | 139 +++++++++++++
 tb/tb_cart_bank_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cart_bank_ctrl.sv
// Cartridge bank controller: maps 6502 ROM accesses through F8/F6/F4 hotspot banking
// and sequences SPI cartridge loads into ROM port B while the CPU is held in reset.
module cart_bank_ctrl #(
    parameter int         ROM_AW         = 15,
    parameter logic [1:0] DEFAULT_SCHEME = 2'd0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_enable_i,
    input  logic [12:0]       cpu_addr_i,
    input  logic              spi_wr_i,
    input  logic [31:0]       spi_addr_i,
    input  logic [7:0]        spi_data_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    output logic [ROM_AW-1:0] rom_b_addr_o,
    output logic [7:0]        rom_b_din_o,
    output logic              rom_b_we_o,
    output logic              cpu_hold_o,
    output logic              cpu_reset_o,
    output logic [2:0]        bank_o,
    output logic [1:0]        scheme_o
);

    typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_SETTLE} state_t;

    function automatic logic [2:0] last_bank(input logic [1:0] s);
        case (s)
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            2'd3:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  scheme_q;
    logic [2:0]  bank_q;
    logic        ctrl_load_q;
    logic        settle_cnt_q;

    logic        ctrl_wr, scheme_wr, rom_wr, load_now;
    logic        hot_hit;
    logic [2:0]  hot_bank;
    logic [11:0] off4, off6, off8;

    assign ctrl_wr   = spi_wr_i && (spi_addr_i[31:24] == 8'hFF);
    assign scheme_wr = spi_wr_i && (spi_addr_i[31:24] == 8'hFE) && (state_q == ST_LOAD);
    assign rom_wr    = spi_wr_i && (spi_addr_i[31:24] == 8'h00) &&
                       ((spi_addr_i[23:0] >> ROM_AW) == 24'd0) && (state_q == ST_LOAD);
    // Only the LOAD bit of the control byte matters; the write data wins over the stored copy.
    assign load_now  = ctrl_wr ? spi_data_i[1] : ctrl_load_q;

    assign off4 = cpu_addr_i[11:0] - 12'hFF4;
    assign off6 = cpu_addr_i[11:0] - 12'hFF6;
    assign off8 = cpu_addr_i[11:0] - 12'hFF8;

    // Offsets wrap below the hotspot base, so a single unsigned compare bounds the range.
    always_comb begin
        hot_hit  = 1'b0;
        hot_bank = 3'd0;
        if (state_q == ST_RUN && cpu_enable_i && cpu_addr_i[12]) begin
            case (scheme_q)
                2'd1: if (off8 < 12'd2) begin hot_hit = 1'b1; hot_bank = off8[2:0]; end
                2'd2: if (off6 < 12'd4) begin hot_hit = 1'b1; hot_bank = off6[2:0]; end
                2'd3: if (off4 < 12'd8) begin hot_hit = 1'b1; hot_bank = off4[2:0]; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cpu_hold_o  = 1'b0;
        cpu_reset_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (load_now) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                cpu_hold_o  = 1'b1;
                cpu_reset_o = 1'b1;
                if (!load_now) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cpu_hold_o  = 1'b1;
                cpu_reset_o = 1'b1;
                if (load_now)                          state_d = ST_LOAD;
                else if (cpu_enable_i && settle_cnt_q) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scheme_q     <= DEFAULT_SCHEME;
            bank_q       <= last_bank(DEFAULT_SCHEME);
            ctrl_load_q  <= 1'b0;
            settle_cnt_q <= 1'b0;
            rom_b_we_o   <= 1'b0;
            rom_b_addr_o <= '0;
            rom_b_din_o  <= 8'd0;
        end else begin
            if (ctrl_wr)   ctrl_load_q <= spi_data_i[1];
            if (scheme_wr) scheme_q    <= spi_data_i[1:0];
            if (state_d == ST_SETTLE) bank_q <= last_bank(scheme_q);
            else if (hot_hit)         bank_q <= hot_bank;
            // Counter restarts on every entry into SETTLE, including re-entry after LOAD.
            settle_cnt_q <= (state_q == ST_SETTLE && state_d == ST_SETTLE) ?
                            (settle_cnt_q | cpu_enable_i) : 1'b0;
            rom_b_we_o <= rom_wr;
            if (rom_wr) begin
                rom_b_addr_o <= spi_addr_i[ROM_AW-1:0];
                rom_b_din_o  <= spi_data_i;
            end
        end
    end

    generate
        if (ROM_AW == 12) begin : g_aw12
            assign rom_addr_o = cpu_addr_i[11:0];
        end else if (ROM_AW < 15) begin : g_awlt15
            assign rom_addr_o = {bank_q[ROM_AW-13:0], cpu_addr_i[11:0]};
        end else if (ROM_AW == 15) begin : g_aw15
            assign rom_addr_o = {bank_q, cpu_addr_i[11:0]};
        end else begin : g_awgt15
            assign rom_addr_o = {{(ROM_AW-15){1'b0}}, bank_q, cpu_addr_i[11:0]};
        end
    endgenerate

    assign bank_o   = bank_q;
    assign scheme_o = scheme_q;

endmodule

// File: tb/tb_cart_bank_ctrl.sv
// Directed bench for cart_bank_ctrl (F8 default): reset, loads, hotspots, guards, collisions.
module tb_cart_bank_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        cpu_enable_i = 1'b0;
    logic [12:0] cpu_addr_i = 13'd0;
    logic        spi_wr_i = 1'b0;
    logic [31:0] spi_addr_i = 32'd0;
    logic [7:0]  spi_data_i = 8'd0;
    logic [14:0] rom_addr_o, rom_b_addr_o;
    logic [7:0]  rom_b_din_o;
    logic        rom_b_we_o, cpu_hold_o, cpu_reset_o;
    logic [2:0]  bank_o;
    logic [1:0]  scheme_o;

    int n_cmp = 0;
    int n_err = 0;

    cart_bank_ctrl #(.ROM_AW(15), .DEFAULT_SCHEME(2'd1)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .cpu_enable_i(cpu_enable_i), .cpu_addr_i(cpu_addr_i),
        .spi_wr_i(spi_wr_i), .spi_addr_i(spi_addr_i), .spi_data_i(spi_data_i),
        .rom_addr_o(rom_addr_o), .rom_b_addr_o(rom_b_addr_o), .rom_b_din_o(rom_b_din_o),
        .rom_b_we_o(rom_b_we_o), .cpu_hold_o(cpu_hold_o), .cpu_reset_o(cpu_reset_o),
        .bank_o(bank_o), .scheme_o(scheme_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one SPI byte for one cycle; returns at the following negedge.
    task automatic spi_write(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk_i);
        spi_wr_i = 1'b1; spi_addr_i = a; spi_data_i = d;
        @(negedge clk_i);
        spi_wr_i = 1'b0;
    endtask

    task automatic strobe(input logic [12:0] a);
        @(negedge clk_i);
        cpu_enable_i = 1'b1; cpu_addr_i = a;
        @(negedge clk_i);
        cpu_enable_i = 1'b0;
    endtask

    initial begin
        // Reset state, F8 default
        cpu_addr_i = 13'h0123;
        #12;
        chk("rst_bank", bank_o, 3'd1);
        chk("rst_scheme", scheme_o, 2'd1);
        chk("rst_rom_addr", rom_addr_o, 15'h1123);
        chk("rst_hold", cpu_hold_o, 1'b0);
        chk("rst_cpu_reset", cpu_reset_o, 1'b0);
        chk("rst_we", rom_b_we_o, 1'b0);
        chk("rst_b_addr", rom_b_addr_o, 15'h0);
        chk("rst_b_din", rom_b_din_o, 8'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Load F6 image
        spi_write(32'hFF000000, 8'h02);
        chk("load_hold", cpu_hold_o, 1'b1);
        chk("load_cpu_reset", cpu_reset_o, 1'b1);
        spi_write(32'hFE000000, 8'h02);
        chk("scheme_f6", scheme_o, 2'd2);
        spi_write(32'h00001234, 8'hA5);
        chk("romwr_we", rom_b_we_o, 1'b1);
        chk("romwr_addr", rom_b_addr_o, 15'h1234);
        chk("romwr_din", rom_b_din_o, 8'hA5);
        @(negedge clk_i);
        chk("romwr_we_drop", rom_b_we_o, 1'b0);
        spi_write(32'h00008000, 8'h5A);
        chk("romwr_oob_we", rom_b_we_o, 1'b0);
        strobe(13'h1FF6);
        chk("load_no_bank_change", bank_o, 3'd1);
        spi_write(32'hFF000000, 8'h00);
        chk("settle_bank_f6", bank_o, 3'd3);
        chk("settle_hold", cpu_hold_o, 1'b1);
        strobe(13'h1000);
        chk("settle_1strobe_hold", cpu_hold_o, 1'b1);
        strobe(13'h1000);
        chk("settle_2strobe_hold", cpu_hold_o, 1'b0);
        chk("settle_2strobe_rst", cpu_reset_o, 1'b0);

        // F6 hotspots
        strobe(13'h1FF7);
        chk("f6_ff7_bank", bank_o, 3'd1);
        strobe(13'h1FF8);
        cpu_addr_i = 13'h0ABC;
        #1;
        chk("f6_ff8_rom_addr", rom_addr_o, 15'h2ABC);
        @(negedge clk_i);
        cpu_addr_i = 13'h1FF7;
        @(negedge clk_i);
        chk("f6_no_enable", bank_o, 3'd2);
        strobe(13'h0FF8);
        chk("f6_a12_low", bank_o, 3'd2);
        strobe(13'h1FFA);
        chk("f6_out_of_range", bank_o, 3'd2);

        // Guard writes in RUN
        spi_write(32'h00000010, 8'h77);
        chk("guard_romwr_run", rom_b_we_o, 1'b0);
        spi_write(32'hFE000000, 8'h03);
        chk("guard_scheme_run", scheme_o, 2'd2);
        spi_write(32'hFF000000, 8'h00);
        chk("guard_load0_run", cpu_hold_o, 1'b0);

        // Load F4
        spi_write(32'hFF000000, 8'h02);
        spi_write(32'hFE000000, 8'h03);
        chk("scheme_f4", scheme_o, 2'd3);
        spi_write(32'hFF000000, 8'h00);
        chk("settle_bank_f4", bank_o, 3'd7);
        strobe(13'h1000);
        strobe(13'h1000);
        chk("f4_run", cpu_hold_o, 1'b0);
        strobe(13'h1FF4);
        chk("f4_ff4_bank", bank_o, 3'd0);
        strobe(13'h1FF9);
        cpu_addr_i = 13'h0123;
        #1;
        chk("f4_ff9_rom_addr", rom_addr_o, 15'h5123);
        strobe(13'h1FFB);
        chk("f4_ffb_bank", bank_o, 3'd7);
        strobe(13'h1FFC);
        chk("f4_ffc_unchanged", bank_o, 3'd7);

        // Load F8 then collide hotspot with LOAD=1
        spi_write(32'hFF000000, 8'h02);
        spi_write(32'hFE000000, 8'h01);
        spi_write(32'hFF000000, 8'h00);
        chk("settle_bank_f8", bank_o, 3'd1);
        strobe(13'h1000);
        strobe(13'h1000);
        @(negedge clk_i);
        cpu_enable_i = 1'b1; cpu_addr_i = 13'h1FF8;
        spi_wr_i = 1'b1; spi_addr_i = 32'hFF000000; spi_data_i = 8'h02;
        @(negedge clk_i);
        cpu_enable_i = 1'b0; spi_wr_i = 1'b0;
        chk("collide_bank", bank_o, 3'd0);
        chk("collide_hold", cpu_hold_o, 1'b1);
        spi_write(32'hFF000000, 8'h00);
        chk("collide_settle_bank", bank_o, 3'd1);
        strobe(13'h1000);
        spi_write(32'hFF000000, 8'h02);
        chk("reload_from_settle", cpu_hold_o, 1'b1);
        spi_write(32'hFF000000, 8'h00);
        strobe(13'h1000);
        chk("settle_count_discarded", cpu_hold_o, 1'b1);
        strobe(13'h1000);
        chk("settle_after_reload_run", cpu_hold_o, 1'b0);

        // Async reset mid-load with a ROM write in flight
        spi_write(32'hFF000000, 8'h02);
        @(negedge clk_i);
        spi_wr_i = 1'b1; spi_addr_i = 32'h00000100; spi_data_i = 8'h3C;
        @(posedge clk_i);
        #2;
        spi_wr_i = 1'b0;
        chk("pre_reset_we", rom_b_we_o, 1'b1);
        #1 rst_n_i = 1'b0;
        #1;
        chk("async_we", rom_b_we_o, 1'b0);
        chk("async_b_addr", rom_b_addr_o, 15'h0);
        chk("async_b_din", rom_b_din_o, 8'h0);
        chk("async_hold", cpu_hold_o, 1'b0);
        chk("async_cpu_reset", cpu_reset_o, 1'b0);
        chk("async_scheme", scheme_o, 2'd1);
        chk("async_bank", bank_o, 3'd1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("post_reset_hold", cpu_hold_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
